// File: rtl/crossbar_switch.sv
// eFPGA tile routing crossbar: 72x32 config shift chain, OR-masked crosspoints.
// Define CROSSBAR_OUT_REG_EN to register the edge outputs (1-cycle latency).
module crossbar_switch (
  input  logic        clk,
  input  logic        nres,
  input  logic [31:0] prog_i,
  input  logic        prog_shft,
  output logic [31:0] prog_o,
  input  logic [31:0] N_i,
  output logic [31:0] S_o,
  input  logic [15:0] S_i,
  output logic [15:0] N_o,
  input  logic [31:0] W_i,
  output logic [31:0] E_o,
  input  logic [15:0] E_i,
  output logic [15:0] W_o
);

  logic [31:0] r_cfg [72];

  logic [31:0] w_s;
  logic [15:0] w_n;
  logic [31:0] w_e;
  logic [15:0] w_w;

  always_ff @(posedge clk or posedge nres) begin
    if (nres) begin
      for (int k = 0; k < 72; k++) begin
        r_cfg[k] <= '0;
      end
    end else if (prog_shft) begin
      r_cfg[0] <= prog_i;
      for (int k = 1; k < 72; k++) begin
        r_cfg[k] <= r_cfg[k-1];
      end
    end
  end

  assign prog_o = r_cfg[71];

  // Word index = bank base + output position; half-words for 16-bit sources.
  always_comb begin
    w_s = '0;
    w_n = '0;
    w_e = '0;
    w_w = '0;
    for (int j = 0; j < 32; j++) begin
      w_s[j] = |(r_cfg[16+j] & N_i);
    end
    for (int j = 0; j < 16; j++) begin
      w_n[j] = |(r_cfg[j] & W_i);
    end
    for (int j = 0; j < 16; j++) begin
      w_e[2*j+1] = |(r_cfg[56+j][31:16] & S_i);
      w_e[2*j]   = |(r_cfg[56+j][15:0]  & S_i);
    end
    for (int j = 0; j < 8; j++) begin
      w_w[2*j+1] = |(r_cfg[48+j][31:16] & E_i);
      w_w[2*j]   = |(r_cfg[48+j][15:0]  & E_i);
    end
  end

`ifdef CROSSBAR_OUT_REG_EN
  logic [31:0] r_s_o;
  logic [15:0] r_n_o;
  logic [31:0] r_e_o;
  logic [15:0] r_w_o;

  always_ff @(posedge clk or posedge nres) begin
    if (nres) begin
      r_s_o <= '0;
      r_n_o <= '0;
      r_e_o <= '0;
      r_w_o <= '0;
    end else begin
      r_s_o <= w_s;
      r_n_o <= w_n;
      r_e_o <= w_e;
      r_w_o <= w_w;
    end
  end

  assign S_o = r_s_o;
  assign N_o = r_n_o;
  assign E_o = r_e_o;
  assign W_o = r_w_o;
`else
  assign S_o = w_s;
  assign N_o = w_n;
  assign E_o = w_e;
  assign W_o = w_w;
`endif

endmodule

// File: tb/tb_crossbar_switch.sv
// Directed bench for crossbar_switch (combinational-output build).
// Expected values are hand-derived from the bank/mask layout.
module tb_crossbar_switch;

  logic        clk;
  logic        nres;
  logic [31:0] prog_i;
  logic        prog_shft;
  logic [31:0] prog_o;
  logic [31:0] N_i;
  logic [31:0] S_o;
  logic [15:0] S_i;
  logic [15:0] N_o;
  logic [31:0] W_i;
  logic [31:0] E_o;
  logic [15:0] E_i;
  logic [15:0] W_o;

  int n_pass;
  int n_chk;

  logic [31:0] img [72];

  crossbar_switch dut (
    .clk       (clk),
    .nres      (nres),
    .prog_i    (prog_i),
    .prog_shft (prog_shft),
    .prog_o    (prog_o),
    .N_i       (N_i),
    .S_o       (S_o),
    .S_i       (S_i),
    .N_o       (N_o),
    .W_i       (W_i),
    .E_o       (E_o),
    .E_i       (E_i),
    .W_o       (W_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
  endtask

  task automatic shift(input logic [31:0] w);
    prog_i    = w;
    prog_shft = 1'b1;
    @(posedge clk);
    #1;
    prog_shft = 1'b0;
  endtask

  task automatic clr_img();
    for (int k = 0; k < 72; k++) img[k] = '0;
  endtask

  task automatic load_img();
    for (int k = 0; k < 72; k++) shift(img[k]);
  endtask

  logic [15:0] hi;
  logic [15:0] lo;
  logic [31:0] s_keep;

  initial begin
    n_pass    = 0;
    n_chk     = 0;
    nres      = 1'b1;
    prog_i    = 32'hdeadbeef;
    prog_shft = 1'b0;
    N_i       = 32'h87654321;
    W_i       = 32'h0fedcba9;
    S_i       = 16'hffff;
    E_i       = 16'hffff;
    #3;
    chk("rst_prog_o", prog_o, 32'h0);
    chk("rst_S_o", S_o, 32'h0);
    chk("rst_N_o", {16'h0, N_o}, 32'h0);
    chk("rst_E_o", E_o, 32'h0);
    chk("rst_W_o", {16'h0, W_o}, 32'h0);
    @(posedge clk);
    #1;
    nres = 1'b0;

    // identity on bank S
    clr_img();
    for (int m = 0; m < 32; m++) img[24+m] = 32'h80000000 >> m;
    load_img();
    chk("id_S_o", S_o, 32'h87654321);
    chk("id_E_o", E_o, 32'h0);
    chk("id_W_o", {16'h0, W_o}, 32'h0);
    chk("id_N_o", {16'h0, N_o}, 32'h0);
    chk("id_prog_o", prog_o, 32'h0);
    N_i = 32'h13579bdf;
    #1;
    chk("id_S_o2", S_o, 32'h13579bdf);

    // hold: prog_i toggles without shift enable
    s_keep = S_o;
    for (int c = 0; c < 4; c++) begin
      prog_i = (c % 2 == 0) ? 32'hffffffff : 32'h0;
      @(posedge clk);
      #1;
    end
    chk("hold_S_o", S_o, 32'h13579bdf);
    chk("hold_prog_o", prog_o, 32'h0);
    N_i = 32'h87654321;

    // bank W pattern
    clr_img();
    for (int m = 0; m < 8; m++) begin
      if (m < 4) begin
        hi = 16'h0003 << (4 * m);
        lo = 16'h000c << (4 * m);
      end else begin
        hi = 16'h000c << (4 * (m - 4));
        lo = 16'h0003 << (4 * (m - 4));
      end
      img[16+m] = {hi, lo};
    end
    E_i = 16'h5a5a;
    load_img();
    chk("bw_W_o_5a5a", {16'h0, W_o}, 32'h0000ffff);
    chk("bw_S_o", S_o, 32'h0);
    chk("bw_E_o", E_o, 32'h0);
    E_i = 16'h000f;
    #1;
    chk("bw_W_o_000f", {16'h0, W_o}, 32'h0000c0c0);
    E_i = 16'h0000;
    #1;
    chk("bw_W_o_0", {16'h0, W_o}, 32'h0);

    // bank E first word
    clr_img();
    img[0] = 32'h80000001;
    S_i = 16'h8000;
    load_img();
    chk("be_prog_o", prog_o, 32'h80000001);
    chk("be_E_o_hi", E_o, 32'h80000000);
    S_i = 16'h0001;
    #1;
    chk("be_E_o_lo", E_o, 32'h40000000);

    // passthrough and excess words
    for (int k = 0; k < 72; k++) img[k] = 32'ha5000000 | k;
    load_img();
    chk("pt_w0", prog_o, 32'ha5000000);
    shift(32'hfedcab98);
    chk("pt_w1", prog_o, 32'ha5000001);
    shift(32'h87654321);
    chk("pt_w2", prog_o, 32'ha5000002);
    shift(32'haaaa5555);
    chk("pt_w3", prog_o, 32'ha5000003);
    for (int k = 0; k < 69; k++) shift(32'h0);
    chk("pt_x0", prog_o, 32'hfedcab98);
    shift(32'h0);
    chk("pt_x1", prog_o, 32'h87654321);
    shift(32'h0);
    chk("pt_x2", prog_o, 32'haaaa5555);

    // multi-source OR on N_o[15]
    clr_img();
    img[56] = 32'h00000003;
    W_i = 32'h00000002;
    load_img();
    chk("or_N_o_2", {16'h0, N_o}, 32'h00008000);
    W_i = 32'h0;
    #1;
    chk("or_N_o_0", {16'h0, N_o}, 32'h0);
    W_i = 32'h00000001;
    #1;
    chk("or_N_o_1", {16'h0, N_o}, 32'h00008000);

    // asynchronous reset mid-load
    for (int k = 0; k < 72; k++) img[k] = 32'ha5000000 | k;
    load_img();
    for (int k = 0; k < 5; k++) shift(32'hffffffff);
    chk("mr_pre", prog_o, 32'ha5000005);
    N_i = 32'hffffffff;
    W_i = 32'hffffffff;
    S_i = 16'hffff;
    E_i = 16'hffff;
    #2;
    nres = 1'b1;
    #1;
    chk("mr_prog_o", prog_o, 32'h0);
    chk("mr_S_o", S_o, 32'h0);
    chk("mr_N_o", {16'h0, N_o}, 32'h0);
    chk("mr_E_o", E_o, 32'h0);
    chk("mr_W_o", {16'h0, W_o}, 32'h0);
    @(posedge clk);
    #1;
    nres = 1'b0;
    shift(32'h12345678);
    chk("mr_resume", prog_o, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
